// File: rtl/median_window_fetch.sv
// Frame-level fetch controller for a 3x3 median filter over a 64x64
// column-major image. It walks every centre pixel and reads the nine
// mirrored-boundary window taps from a synchronous pixel RAM, one per cycle.
// It then offers the assembled window to the sorter over a valid/ready handshake.
module median_window_fetch #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 13,
    parameter int RAM_LAT = 1
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iStart,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [5:0]            oStartRow,
    output logic [5:0]            oStartCol,
    input  logic [ADDR_W-1:0]     iAddrP11,
    input  logic [ADDR_W-1:0]     iAddrP12,
    input  logic [ADDR_W-1:0]     iAddrP13,
    input  logic [ADDR_W-1:0]     iAddrP21,
    input  logic [ADDR_W-1:0]     iAddrP22,
    input  logic [ADDR_W-1:0]     iAddrP23,
    input  logic [ADDR_W-1:0]     iAddrP31,
    input  logic [ADDR_W-1:0]     iAddrP32,
    input  logic [ADDR_W-1:0]     iAddrP33,
    output logic [ADDR_W-1:0]     oRamAddr,
    output logic                  oRamRd,
    input  logic [DATA_W-1:0]     iRamData,
    output logic [9*DATA_W-1:0]   oWin,
    output logic                  oWinValid,
    input  logic                  iWinReady,
    output logic [5:0]            oWinRow,
    output logic [5:0]            oWinCol
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_TAP   = 4'd8;
    localparam logic [1:0] LAST_DRAIN = 2'(RAM_LAT - 1);
    localparam logic [5:0] EDGE_POS   = 6'd63;

    state_t              state;
    state_t              next_state;
    logic [5:0]          row;
    logic [5:0]          col;
    logic [3:0]          tap_cnt;
    logic [1:0]          drain_cnt;
    logic                last_win;
    logic [ADDR_W-1:0]   tap_addr [9];
    logic                cap_vld  [RAM_LAT];
    logic [3:0]          cap_tap  [RAM_LAT];
    logic [9*DATA_W-1:0] win_q;

    assign last_win = (row == EDGE_POS) && (col == EDGE_POS);

    // Decoder taps collected in window order (P11..P33) for the fetch mux.
    always_comb begin
        tap_addr[0] = iAddrP11;
        tap_addr[1] = iAddrP12;
        tap_addr[2] = iAddrP13;
        tap_addr[3] = iAddrP21;
        tap_addr[4] = iAddrP22;
        tap_addr[5] = iAddrP23;
        tap_addr[6] = iAddrP31;
        tap_addr[7] = iAddrP32;
        tap_addr[8] = iAddrP33;
    end

    // State register.
    always_ff @(posedge iClk or negedge iRst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before the clock edge.
        if (!iRst_n) state <= S_IDLE;
        else         state <= next_state;
    end

    // Next-state selection and state-decoded outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        next_state = state;
        oBusy      = 1'b0;
        oDone      = 1'b0;
        oRamRd     = 1'b0;
        oRamAddr   = '0;
        oWinValid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (iStart) next_state = S_FETCH;
            end
            S_FETCH: begin
                oBusy    = 1'b1;
                oRamRd   = 1'b1;
                oRamAddr = tap_addr[tap_cnt];
                if (tap_cnt == LAST_TAP) next_state = S_DRAIN;
            end
            S_DRAIN: begin
                oBusy = 1'b1;
                if (drain_cnt == LAST_DRAIN) next_state = S_HOLD;
            end
            S_HOLD: begin
                oBusy     = 1'b1;
                oWinValid = 1'b1;
                if (iWinReady) next_state = last_win ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                oDone      = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Scan position, tap counter and drain counter.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            row       <= '0;
            col       <= '0;
            tap_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iStart) begin
                        row     <= '0;
                        col     <= '0;
                        tap_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    tap_cnt   <= (tap_cnt == LAST_TAP) ? 4'd0 : tap_cnt + 4'd1;
                    drain_cnt <= '0;
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + 2'd1;
                end
                S_HOLD: begin
                    // Row is the inner scan loop; both wraps are explicit compares.
                    if (iWinReady && !last_win) begin
                        if (row == EDGE_POS) begin
                            row <= '0;
                            col <= col + 6'd1;
                        end else begin
                            row <= row + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture pipeline: tap index travels alongside each read and steers the data into its slot.
    always_ff @(posedge iClk or negedge iRst_n) begin
        // NOTE: the window register is reset because it drives a visible output
        // that must read 0 after reset; clearing the capture valids discards any
        // read still in flight.
        if (!iRst_n) begin
            for (int i = 0; i < RAM_LAT; i++) begin
                cap_vld[i] <= 1'b0;
                cap_tap[i] <= '0;
            end
            win_q <= '0;
        end else begin
            cap_vld[0] <= oRamRd;
            cap_tap[0] <= tap_cnt;
            for (int i = 1; i < RAM_LAT; i++) begin
                cap_vld[i] <= cap_vld[i-1];
                cap_tap[i] <= cap_tap[i-1];
            end
            if (cap_vld[RAM_LAT-1]) begin
                win_q[cap_tap[RAM_LAT-1]*DATA_W +: DATA_W] <= iRamData;
            end
        end
    end

    assign oStartRow = row;
    assign oStartCol = col;
    assign oWinRow   = row;
    assign oWinCol   = col;
    assign oWin      = win_q;

endmodule
